// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_pkg
//  Description : RV32I load/store size codes, controller states and the
//                access legality check shared by the memory access controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        MRG  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    // Stores only exist in B/H/W flavours; loads reject the three unused codes.
    function automatic logic access_err(input logic       write,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        if (write) begin
            illegal = (funct3 > c_F3_W);
        end else begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        misaligned = (((funct3 == c_F3_H) || (funct3 == c_F3_HU)) && addr_lo[0])
                   || ((funct3 == c_F3_W) && (addr_lo != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl_if
//  Description : Core-side request/response handshake of the memory access
//                controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface
`default_nettype wire

// File: rtl/load_store_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_align
//  Description : Combinational load lane extract/extend and store lane merge.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_byte_off,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'd0;
        case (i_byte_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = 8'd0;
        endcase
        w_half = i_byte_off[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_load_data = i_rdata;
        case (i_funct3)
            c_F3_B:  o_load_data = {{24{w_byte[7]}}, w_byte};
            c_F3_H:  o_load_data = {{16{w_half[15]}}, w_half};
            c_F3_BU: o_load_data = {24'd0, w_byte};
            c_F3_HU: o_load_data = {16'd0, w_half};
            default: o_load_data = i_rdata;
        endcase

        // Untouched lanes keep the word just read back from memory.
        o_store_word = i_rdata;
        case (i_funct3)
            c_F3_B: begin
                case (i_byte_off)
                    2'd0:    o_store_word[7:0]   = i_wdata[7:0];
                    2'd1:    o_store_word[15:8]  = i_wdata[7:0];
                    2'd2:    o_store_word[23:16] = i_wdata[7:0];
                    2'd3:    o_store_word[31:24] = i_wdata[7:0];
                    default: o_store_word        = i_rdata;
                endcase
            end
            c_F3_H: begin
                if (i_byte_off[1]) begin
                    o_store_word[31:16] = i_wdata[15:0];
                end else begin
                    o_store_word[15:0]  = i_wdata[15:0];
                end
            end
            default: o_store_word = i_wdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : Sequences RV32I loads/stores onto a single-port word memory,
//                using read-modify-write for byte and halfword stores.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int WORDS      = 64,
    parameter int ADDR_WIDTH = $clog2(WORDS)
)(
    input  logic                  clk,
    input  logic                  rst,
    mem_access_ctrl_if.slave      bus,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic                  mem_write_enable,
    input  logic [31:0]           mem_read_data
);

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_accept;
    logic                  w_req_err;
    logic                  r_write;
    logic [2:0]            r_funct3;
    logic [1:0]            r_byte_off;
    logic [31:0]           r_wdata;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [31:0]           r_rsp_rdata;
    logic                  r_rsp_err;
    logic [31:0]           w_load_data;
    logic [31:0]           w_store_word;

    assign w_req_err     = access_err(bus.req_write, bus.req_funct3, bus.req_addr[1:0]);
    assign mem_address   = r_mem_address;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    load_store_align u_align (
        .i_funct3     (r_funct3),
        .i_byte_off   (r_byte_off),
        .i_rdata      (mem_read_data),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Write strobe is gated by rst so an aborted request never reaches memory.
    always_comb begin
        w_next_state     = r_state;
        w_accept         = 1'b0;
        bus.req_ready    = 1'b0;
        bus.rsp_valid    = 1'b0;
        mem_write_enable = 1'b0;
        mem_write_data   = 32'd0;
        case (r_state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    if (w_req_err) begin
                        w_next_state = RESP;
                    end else if (bus.req_write && (bus.req_funct3 == c_F3_W)) begin
                        w_next_state = WR;
                    end else begin
                        w_next_state = RD;
                    end
                end
            end
            RD: begin
                w_next_state = MRG;
            end
            MRG: begin
                w_next_state = RESP;
                if (r_write) begin
                    mem_write_enable = !rst;
                    mem_write_data   = w_store_word;
                end
            end
            WR: begin
                w_next_state     = RESP;
                mem_write_enable = !rst;
                mem_write_data   = r_wdata;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_write       <= 1'b0;
            r_funct3      <= 3'd0;
            r_byte_off    <= 2'd0;
            r_wdata       <= 32'd0;
            r_mem_address <= '0;
            r_rsp_rdata   <= 32'd0;
            r_rsp_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write       <= bus.req_write;
                r_funct3      <= bus.req_funct3;
                r_byte_off    <= bus.req_addr[1:0];
                r_wdata       <= bus.req_wdata;
                r_mem_address <= bus.req_addr[ADDR_WIDTH+1:2];
                r_rsp_err     <= w_req_err;
                r_rsp_rdata   <= 32'd0;
            end
            if (r_state == MRG) begin
                r_rsp_rdata <= r_write ? 32'd0 : w_load_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter WORDS, default 64, meaning the depth of the attached word memory.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default $clog2(WORDS), meaning the width of the memory word address.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1, meaning a core access request is present.
REQ-006 The block SHALL have port req_ready, output, 1, meaning the block can accept a request.
REQ-007 The block SHALL have port req_write, input, 1, where 1 = store and 0 = load.
REQ-008 The block SHALL have port req_addr, input, 32, the byte address.
REQ-009 The block SHALL have port req_wdata, input, 32, the store data, right-aligned.
REQ-010 The block SHALL have port req_funct3, input, 3, the RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 The block SHALL have port rsp_valid, output, 1, meaning a response is present.
REQ-012 The block SHALL have port rsp_ready, input, 1, meaning the consumer accepts the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32, the load result, extended; 0 for stores.
REQ-014 The block SHALL have port rsp_err, output, 1, flagging a misaligned or illegal access.
REQ-015 The block SHALL have port mem_address, output, ADDR_WIDTH, the word address to the memory.
REQ-016 The block SHALL have port mem_write_data, output, 32, the word written to the memory.
REQ-017 The block SHALL have port mem_write_enable, output, 1, the memory write strobe.
REQ-018 The block SHALL have port mem_read_data, input, 32, the memory read word, valid one cycle after its address is presented.

Function
REQ-019 The FSM SHALL have states IDLE, RD, MRG, WR and RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 On req_valid && req_ready, the block SHALL register addr, wdata, funct3 and write; the word address SHALL be req_addr[ADDR_WIDTH+1:2], with upper bits ignored (wrap).
REQ-021 A misaligned access (H/HU with addr[0]=1; W with addr[1:0]!=0) or an illegal funct3 (load 011/110/111; store funct3>010) SHALL go IDLE->RESP with rsp_err=1 and rsp_rdata=0, and SHALL NOT write memory.
REQ-022 A load SHALL follow IDLE->RD->MRG->RESP; rsp_valid first asserts 3 cycles after the accept edge.
REQ-023 A load SHALL select the byte by addr[1:0] or the halfword by addr[1], sign-extending for B/H and zero-extending for BU/HU.
REQ-024 An SW store SHALL follow IDLE->WR->RESP with mem_write_enable=1 for exactly the WR cycle, writing req_wdata.
REQ-025 An SB/SH store SHALL follow IDLE->RD->MRG->RESP as read-modify-write; in MRG mem_write_enable=1 and mem_write_data SHALL be mem_read_data with only the addressed lanes replaced by wdata[7:0]/[15:0].
REQ-026 mem_write_enable SHALL be asserted in at most one cycle per request, and never outside WR/MRG.
REQ-027 RESP SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready; on rsp_ready the FSM SHALL go to IDLE, with no back-to-back accept in that same cycle.
REQ-028 mem_address SHALL hold the registered word address from RD through MRG/WR.

Reset
REQ-029 When rst=1 at an edge, the block SHALL force state to IDLE, rsp_valid, rsp_err and mem_write_enable to 0, and rsp_rdata, mem_address and mem_write_data to 0.
REQ-030 Reset mid-operation SHALL abort the request, with no memory write from the reset cycle onward and no response issued.

Structure
REQ-031 Package mem_access_pkg SHALL hold the funct3 localparams and the FSM state enum.
REQ-032 A combinational sub-module load_store_align SHALL perform load extract/extend and store lane merge.

Verification
REQ-033 With mem[3]=0x8899AABB, an LB at 0x0D SHALL produce rsp_rdata=0xFFFFFFAA at accept+3 with rsp_err=0.
REQ-034 With mem[3]=0x8899AABB, an LHU at 0x0E SHALL produce rsp_rdata=0x00008899.
REQ-035 An SB at 0x0D with wdata 0x55 SHALL leave mem[3]=0x889955BB, and a following LW at 0x0C SHALL return 0x889955BB.
REQ-036 An SW at 0x10 with wdata 0xDEADBEEF SHALL pulse mem_write_enable once, and rsp_valid SHALL assert at accept+2.
REQ-037 An LW at 0x0E SHALL assert rsp_err=1 at accept+1 with mem_write_enable never asserted; with rsp_ready=0 for 4 cycles the response SHALL hold.
REQ-038 rst=1 in the RD cycle of an SH SHALL leave memory unchanged, rsp_valid=0 and req_ready=1 on the next cycle.
